spi_sl_burst: RTL

Parametrised SPI slave with an integrated register bank. Supports all four SPI modes, configurable data/address widths and bank depth, and multi-word burst transfers with address auto-increment. The whole block runs on the system clock `sclk`: the SPI pins are oversampled through synchronisers, so no logic is clocked by the SPI clock. It sits between the board SPI header and the control registers that drive the internal system.

---
 rtl/spi_sl_burst_if.sv | 26 ++
 rtl/spi_sl_burst.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spi_sl_burst_if.sv
// spi_sl_burst_if: SPI pins plus the register-write and frame-event bus of spi_sl_burst
interface spi_sl_burst_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              frame_abort;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data, frame_done, frame_abort
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data, frame_done, frame_abort
    );
endinterface

// File: rtl/spi_sl_burst.sv
// spi_sl_burst: SPI slave with burst register bank, pins oversampled on sclk.
// Optional macro SPI_SL_BURST_STATUS_EN turns the top register into a read-only abort counter.
module spi_sl_burst #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 64,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input logic           sclk,
    input logic           rstn,
    spi_sl_burst_if.slave bus
);
    localparam int                CW        = $clog2((DATA_W > ADDR_W + 1 ? DATA_W : ADDR_W + 1) + 1);
    localparam logic [ADDR_W:0]   NR        = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(NUM_REGS - 1);
    localparam bit                SAMP_RISE = (CPOL != 0) == (CPHA != 0);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state, state_nxt;
    logic              sck_m, sck_q, sck_d, cs_m, cs_q, cs_d, mosi_m, mosi_q;
    logic              samp, shft, cs_rise, cs_fall, armed;
    logic              hdr_last, word_last, rwb, miso_r, oe;
    logic [CW-1:0]     bit_cnt;
    logic [ADDR_W-1:0] hdr, ptr, ptr_inc;
    logic [ADDR_W:0]   hdr_nxt;
    logic [DATA_W-1:0] sr, word;
    logic [DATA_W-1:0] regs [NUM_REGS];
`ifdef SPI_SL_BURST_STATUS_EN
    logic [7:0]        abort_cnt;
`endif

    function automatic logic in_bank(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    function automatic logic writable(input logic [ADDR_W-1:0] a);
`ifdef SPI_SL_BURST_STATUS_EN
        return in_bank(a) && a != LAST;
`else
        return in_bank(a);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] reg_rd(input logic [ADDR_W-1:0] a);
`ifdef SPI_SL_BURST_STATUS_EN
        if (a == LAST) return DATA_W'(abort_cnt);
`endif
        return in_bank(a) ? regs[a] : '0;
    endfunction

    // two-flop synchronisers plus one delay stage on sck and cs_n for edge detection
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            {sck_m, sck_q, sck_d} <= '0;
            {cs_m, cs_q, cs_d}    <= '0;
            {mosi_m, mosi_q}      <= '0;
        end else begin
            {sck_m, sck_q, sck_d} <= {bus.spi_sck, sck_m, sck_q};
            {cs_m, cs_q, cs_d}    <= {bus.spi_cs_n, cs_m, cs_q};
            {mosi_m, mosi_q}      <= {bus.spi_mosi, mosi_m};
        end
    end

    // edge roles; sck edges only count while cs is low, so a cs rise always beats a sample
    always_comb begin
        samp    = !cs_q && (SAMP_RISE ? (sck_q && !sck_d) : (!sck_q && sck_d));
        shft    = !cs_q && (SAMP_RISE ? (!sck_q && sck_d) : (sck_q && !sck_d));
        cs_rise = cs_q && !cs_d;
        cs_fall = !cs_q && cs_d;
    end

    // frame state register
    always_ff @(posedge sclk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // frame sequencing; a frame only starts once cs has been seen high since reset
    always_comb begin
        state_nxt = state;
        if (state == IDLE)     state_nxt = (armed && cs_fall) ? HDR : IDLE;
        else if (cs_rise)      state_nxt = IDLE;
        else if (state == HDR) state_nxt = (samp && hdr_last) ? DATA : HDR;
    end

    // word decode and MISO drive
    always_comb begin
        hdr_nxt         = {hdr, mosi_q};
        hdr_last        = bit_cnt == CW'(ADDR_W);
        word_last       = bit_cnt == CW'(DATA_W - 1);
        word            = {sr[DATA_W-2:0], mosi_q};
        ptr_inc         = ptr == LAST ? '0 : ptr + ADDR_W'(1);
        oe              = rwb && state == DATA && !cs_q;
        bus.spi_miso_oe = oe;
        bus.spi_miso    = oe && miso_r;
    end

    // header capture, data shifting, register writes and frame-end pulses
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            armed           <= 1'b0;
            rwb             <= 1'b0;
            miso_r          <= 1'b0;
            bit_cnt         <= '0;
            hdr             <= '0;
            ptr             <= '0;
            sr              <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_abort <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            armed           <= armed || cs_q;
            bus.wr_en       <= 1'b0;
            bus.frame_done  <= cs_rise && state != IDLE && bit_cnt == '0;
            bus.frame_abort <= cs_rise && state != IDLE && bit_cnt != '0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                miso_r  <= 1'b0;
            end
            if (state == HDR && samp) begin
                hdr     <= hdr_nxt[ADDR_W-1:0];
                bit_cnt <= hdr_last ? '0 : bit_cnt + CW'(1);
                if (hdr_last) begin
                    rwb <= hdr_nxt[ADDR_W];
                    ptr <= hdr_nxt[ADDR_W-1:0];
                    sr  <= reg_rd(hdr_nxt[ADDR_W-1:0]);
                end
            end
            if (state == DATA && samp) begin
                bit_cnt <= word_last ? '0 : bit_cnt + CW'(1);
                if (!rwb) sr <= word;
                if (word_last) begin
                    ptr <= ptr_inc;
                    if (rwb) sr <= reg_rd(ptr_inc);
                    else if (writable(ptr)) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= ptr;
                        bus.wr_data <= word;
                        regs[ptr]   <= word;
                    end
                end
            end
            if (state == DATA && shft && rwb) begin
                miso_r <= sr[DATA_W-1];
                sr     <= {sr[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_SL_BURST_STATUS_EN
    // saturating count of aborted frames, cleared only by reset
    always_ff @(posedge sclk) begin
        if (!rstn)                                      abort_cnt <= '0;
        else if (bus.frame_abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
    end
`endif
endmodule
